prime_stream_checker: RTL and testbench

Consumer end of the prime-number stream. Accepts (number, claimed prime flag) pairs over a valid/ready handshake, independently decides primality by bit-serial trial division, and returns the computed verdict with a mismatch flag. Also keeps running prime and mismatch counts. It sits downstream of the prime generator and acts as an in-design checker of its output.

---
 rtl/prime_stream_checker_if.sv | 30 +++
 rtl/prime_stream_checker.sv | 207 ++++++++++++++++++++
 tb/tb_prime_stream_checker.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/prime_stream_checker_if.sv
// Handshake bundle between the prime generator (master) and prime_stream_checker (slave).
//   in_valid/in_ready   : offer of a (number, claimed primality) pair
//   in_number/in_prime  : number to check and producer's claim
//   out_valid/out_ready : verdict offer back to the consumer
//   out_number          : number the verdict belongs to
//   out_prime           : computed primality
//   out_mismatch        : computed verdict disagrees with the claim
interface prime_stream_checker_if #(
  parameter int unsigned WIDTH = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_number;
  logic             in_prime;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_number;
  logic             out_prime;
  logic             out_mismatch;

  modport master (
    output in_valid, in_number, in_prime, out_ready,
    input  in_ready, out_valid, out_number, out_prime, out_mismatch
  );

  modport slave (
    input  in_valid, in_number, in_prime, out_ready,
    output in_ready, out_valid, out_number, out_prime, out_mismatch
  );
endinterface

// File: rtl/prime_stream_checker.sv
// Consumer-side checker of a prime-number stream: captures (number, claim)
// pairs, decides primality by trial division with a bit-serial restoring
// divider, returns the verdict plus a mismatch flag, and keeps saturating
// counts of prime verdicts and mismatches.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   bus            : prime_stream_checker_if.slave (input pair / verdict handshakes)
//   prime_count    : accepted verdicts with out_prime = 1 (saturating)
//   mismatch_count : accepted verdicts with out_mismatch = 1 (saturating)
//
// Build option: define PRIME_CHECK_ODD_SKIP_EN to test divisors 2, 3, 5, 7, ...
// instead of 2, 3, 4, 5, ... (same verdicts, fewer divisions).
module prime_stream_checker #(
  parameter int unsigned WIDTH   = 11,
  parameter int unsigned COUNT_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  prime_stream_checker_if.slave bus,
  output logic [COUNT_W-1:0]    prime_count,
  output logic [COUNT_W-1:0]    mismatch_count
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned REM_W  = WIDTH + 1;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_DIV,
    S_CHECK,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic               claim_q, claim_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_number_q, out_number_d;
  logic               out_prime_q, out_prime_d;
  logic               out_mismatch_q, out_mismatch_d;
  logic [COUNT_W-1:0] prime_count_q, prime_count_d;
  logic [COUNT_W-1:0] mismatch_count_q, mismatch_count_d;

  logic [PROD_W-1:0]  div_sq_c;
  logic [REM_W-1:0]   rem_shift_c;
  logic [WIDTH-1:0]   div_next_c;

  // Divisor square at full product width so the d*d > n test never truncates.
  assign div_sq_c = PROD_W'(div_q) * PROD_W'(div_q);

  // Partial remainder with the next dividend bit brought down.
  assign rem_shift_c = {rem_q[WIDTH-1:0], shift_q[WIDTH-1]};

  // Next trial divisor.
`ifdef PRIME_CHECK_ODD_SKIP_EN
  assign div_next_c = (div_q == WIDTH'(2)) ? WIDTH'(3) : div_q + WIDTH'(2);
`else
  assign div_next_c = div_q + WIDTH'(1);
`endif

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      n_q              <= '0;
      claim_q          <= 1'b0;
      div_q            <= '0;
      shift_q          <= '0;
      rem_q            <= '0;
      cnt_q            <= '0;
      in_ready_q       <= 1'b1;
      out_valid_q      <= 1'b0;
      out_number_q     <= '0;
      out_prime_q      <= 1'b0;
      out_mismatch_q   <= 1'b0;
      prime_count_q    <= '0;
      mismatch_count_q <= '0;
    end else begin
      state_q          <= state_d;
      n_q              <= n_d;
      claim_q          <= claim_d;
      div_q            <= div_d;
      shift_q          <= shift_d;
      rem_q            <= rem_d;
      cnt_q            <= cnt_d;
      in_ready_q       <= in_ready_d;
      out_valid_q      <= out_valid_d;
      out_number_q     <= out_number_d;
      out_prime_q      <= out_prime_d;
      out_mismatch_q   <= out_mismatch_d;
      prime_count_q    <= prime_count_d;
      mismatch_count_q <= mismatch_count_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d          = state_q;
    n_d              = n_q;
    claim_d          = claim_q;
    div_d            = div_q;
    shift_d          = shift_q;
    rem_d            = rem_q;
    cnt_d            = cnt_q;
    out_number_d     = out_number_q;
    out_prime_d      = out_prime_q;
    out_mismatch_d   = out_mismatch_q;
    prime_count_d    = prime_count_q;
    mismatch_count_d = mismatch_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          n_d     = bus.in_number;
          claim_d = bus.in_prime;
          div_d   = WIDTH'(2);
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        if (n_q < WIDTH'(2)) begin
          out_number_d   = n_q;
          out_prime_d    = 1'b0;
          out_mismatch_d = claim_q;
          state_d        = S_DONE;
        end else if (div_sq_c > PROD_W'(n_q)) begin
          out_number_d   = n_q;
          out_prime_d    = 1'b1;
          out_mismatch_d = ~claim_q;
          state_d        = S_DONE;
        end else begin
          shift_d = n_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      // One restoring-division step per cycle; only the remainder is kept.
      S_DIV: begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        if (rem_shift_c >= REM_W'(div_q)) begin
          rem_d = rem_shift_c - REM_W'(div_q);
        end else begin
          rem_d = rem_shift_c;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CHECK: begin
        if (rem_q == '0) begin
          out_number_d   = n_q;
          out_prime_d    = 1'b0;
          out_mismatch_d = claim_q;
          state_d        = S_DONE;
        end else begin
          div_d   = div_next_c;
          state_d = S_INIT;
        end
      end

      // Counters move only on the verdict handshake and stick at all-ones.
      S_DONE: begin
        if (bus.out_ready) begin
          if (out_prime_q && !(&prime_count_q)) begin
            prime_count_d = prime_count_q + COUNT_W'(1);
          end
          if (out_mismatch_q && !(&mismatch_count_q)) begin
            mismatch_count_d = mismatch_count_q + COUNT_W'(1);
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake flags are registered copies of the upcoming state.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_number   = out_number_q;
  assign bus.out_prime    = out_prime_q;
  assign bus.out_mismatch = out_mismatch_q;
  assign prime_count      = prime_count_q;
  assign mismatch_count   = mismatch_count_q;

endmodule

// File: tb/tb_prime_stream_checker.sv
// Directed bench for prime_stream_checker: reset abort, small numbers, wrong
// claim, divisor-step latency, backpressure and a 2..1000 sweep run in
// lockstep on a COUNT_W=11 and a COUNT_W=4 instance.
module tb_prime_stream_checker;

  localparam int unsigned WIDTH = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  prime_stream_checker_if #(.WIDTH(WIDTH)) bus ();
  prime_stream_checker_if #(.WIDTH(WIDTH)) bus4 ();

  logic [10:0] prime_count;
  logic [10:0] mismatch_count;
  logic [3:0]  prime_count4;
  logic [3:0]  mismatch_count4;

  prime_stream_checker #(.WIDTH(WIDTH), .COUNT_W(11)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .prime_count    (prime_count),
    .mismatch_count (mismatch_count)
  );

  prime_stream_checker #(.WIDTH(WIDTH), .COUNT_W(4)) dut4 (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus4),
    .prime_count    (prime_count4),
    .mismatch_count (mismatch_count4)
  );

  // Second instance sees exactly the same stimulus.
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_number = bus.in_number;
  assign bus4.in_prime  = bus.in_prime;
  assign bus4.out_ready = bus.out_ready;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int i = 2; i * i <= n; i++) begin
      if (n % i == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Offer one pair; returns cycles from accept edge until out_valid is seen.
  task automatic send(input int n, input bit claim, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    bus.in_valid  = 1'b1;
    bus.in_number = WIDTH'(n);
    bus.in_prime  = claim;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Accept the verdict after an optional stall.
  task automatic take(input int stall);
    repeat (stall) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int exp_pc;
    int exp_mc;
    int exp_lat25;
    bit seen;
    bit claim;

    bus.in_valid  = 1'b0;
    bus.in_number = '0;
    bus.in_prime  = 1'b0;
    bus.out_ready = 1'b0;
    exp_pc = 0;
    exp_mc = 0;
`ifdef PRIME_CHECK_ODD_SKIP_EN
    exp_lat25 = 40;
`else
    exp_lat25 = 53;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_number", 32'(bus.out_number), 32'd0);
    check_eq("rst_out_prime", 32'(bus.out_prime), 32'd0);
    check_eq("rst_prime_count", 32'(prime_count), 32'd0);
    check_eq("rst_mismatch_count", 32'(mismatch_count), 32'd0);
    rst = 1'b1;

    // Reset in the middle of dividing 997
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_number = WIDTH'(997);
    bus.in_prime  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("busy_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_prime_count", 32'(prime_count), 32'd0);
    check_eq("abort_mismatch_count", 32'(mismatch_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check_eq("abort_no_verdict", 32'(seen), 32'd0);
    check_eq("abort_idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Small numbers 0..3
    for (int n = 0; n < 4; n++) begin
      claim = is_prime(n);
      send(n, claim, lat);
      check_eq("small_latency", 32'(lat), 32'd2);
      check_eq("small_number", 32'(bus.out_number), 32'(n));
      check_eq("small_prime", 32'(bus.out_prime), 32'(claim));
      check_eq("small_mismatch", 32'(bus.out_mismatch), 32'd0);
      take(0);
      if (claim) exp_pc++;
    end
    check_eq("small_prime_count", 32'(prime_count), 32'd2);
    check_eq("small_mismatch_count", 32'(mismatch_count), 32'd0);

    // Wrong claim on 4
    send(4, 1'b1, lat);
    check_eq("wrong_latency", 32'(lat), 32'd14);
    check_eq("wrong_prime", 32'(bus.out_prime), 32'd0);
    check_eq("wrong_mismatch", 32'(bus.out_mismatch), 32'd1);
    take(0);
    exp_mc++;
    check_eq("wrong_mismatch_count", 32'(mismatch_count), 32'(exp_mc));

    // Divisor step rule shows up in latency of 25
    send(25, 1'b0, lat);
    check_eq("step_latency", 32'(lat), 32'(exp_lat25));
    check_eq("step_prime", 32'(bus.out_prime), 32'd0);
    check_eq("step_mismatch", 32'(bus.out_mismatch), 32'd0);
    take(0);

    // Backpressure on 7
    send(7, 1'b1, lat);
    check_eq("bp_latency", 32'(lat), 32'd15);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_out_number", 32'(bus.out_number), 32'd7);
      check_eq("bp_out_prime", 32'(bus.out_prime), 32'd1);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_prime_count", 32'(prime_count), 32'(exp_pc));
    end
    take(0);
    exp_pc++;
    check_eq("bp_prime_count_after", 32'(prime_count), 32'(exp_pc));
    check_eq("bp_out_valid_after", 32'(bus.out_valid), 32'd0);

    // Sweep 2..1000 with occasional stalls
    for (int n = 2; n <= 1000; n++) begin
      claim = is_prime(n);
      send(n, claim, lat);
      check_eq("sweep_valid", 32'(bus.out_valid), 32'd1);
      check_eq("sweep_number", 32'(bus.out_number), 32'(n));
      check_eq("sweep_prime", 32'(bus.out_prime), 32'(claim));
      check_eq("sweep_mismatch", 32'(bus.out_mismatch), 32'd0);
      check_eq("sweep_prime_w4", 32'(bus4.out_prime), 32'(claim));
      take(($urandom_range(0, 3) == 0) ? 2 : 0);
    end
    // Three primes (2, 3, 7) preceded the sweep's 168.
    check_eq("sweep_prime_count", 32'(prime_count), 32'd171);
    check_eq("sweep_mismatch_count", 32'(mismatch_count), 32'd1);
    check_eq("sat_prime_count", 32'(prime_count4), 32'd15);
    check_eq("sat_mismatch_count", 32'(mismatch_count4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
